// File: rtl/dubl_pkg.sv
// rtl/dubl_pkg.sv - shared state encoding and counter width for the slot arbiter
package dubl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } dubl_state_e;

    localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick of first request at or after a pointer
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  pick_onehot,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    // Walk 2N positions: the first N accept only indices at or after the
    // pointer, the second N accept any index, which yields the wrapped order.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        for (int k = 0; k < 2 * N; k++) begin
            if (!pick_any && req[k % N] && (k >= N || k >= int'(rr_ptr))) begin
                pick_any              = 1'b1;
                pick_idx              = IW'(k % N);
                pick_onehot[k % N]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dubl_slot_arb.sv
// rtl/dubl_slot_arb.sv - round-robin slot arbiter with burst ownership and optional dead slot
module dubl_slot_arb
    import dubl_pkg::*;
#(
    parameter int N  = 4,
    parameter int BW = 3
) (
    input  logic                   dubl_clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [BW-1:0]          cfg_burst,
    input  logic                   cfg_gap,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   gnt_id,
    output logic                   gnt_vld,
    output logic                   slot_phase,
    output logic [GRANT_CNT_W-1:0] grant_cnt
);

    localparam int          IW        = $clog2(N);
    localparam logic [BW:0] BURST_MAX = {1'b1, {BW{1'b0}}};

    dubl_state_e            r_state;
    logic [N-1:0]           r_gnt;
    logic [IW-1:0]          r_gnt_id;
    logic                   r_gnt_vld;
    logic [IW-1:0]          r_rr_ptr;
    logic [BW:0]            r_burst_cnt;
    logic                   r_gap;
    logic [GRANT_CNT_W-1:0] r_grant_cnt;
    logic                   r_slot_phase;

    dubl_state_e            w_state_nxt;
    logic                   w_release;
    logic                   w_arb;
    logic                   w_grant;
    logic [IW-1:0]          w_ptr_adv;
    logic [IW-1:0]          w_pick_ptr;
    logic [N-1:0]           w_pick_onehot;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic [N-1:0]           w_gnt_nxt;
    logic [IW-1:0]          w_id_nxt;
    logic                   w_vld_nxt;
    logic [IW-1:0]          w_ptr_nxt;
    logic [BW:0]            w_burst_nxt;
    logic                   w_gap_nxt;
    logic [GRANT_CNT_W-1:0] w_cnt_nxt;

    // On release the pointer moves past the owner before the same-edge re-arbitration.
    assign w_ptr_adv  = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
    assign w_pick_ptr = w_release ? w_ptr_adv : r_rr_ptr;

    rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .req         (req),
        .rr_ptr      (w_pick_ptr),
        .pick_onehot (w_pick_onehot),
        .pick_idx    (w_pick_idx),
        .pick_any    (w_pick_any)
    );

    // State and all registered outputs; reset clears everything asynchronously.
    always_ff @(posedge dubl_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_gnt_vld    <= 1'b0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_gap        <= 1'b0;
            r_grant_cnt  <= '0;
            r_slot_phase <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_gnt_id     <= w_id_nxt;
            r_gnt_vld    <= w_vld_nxt;
            r_rr_ptr     <= w_ptr_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_gap        <= w_gap_nxt;
            r_grant_cnt  <= w_cnt_nxt;
            r_slot_phase <= ~r_slot_phase;
        end
    end

    // Next state: release on last slot or dropped request; gap latched at grant decides GAP vs re-arbitrate.
    always_comb begin
        w_release   = (r_state == ST_OWN) &&
                      ((r_burst_cnt == (BW + 1)'(1)) || !req[r_gnt_id]);
        w_arb       = (r_state == ST_IDLE) || (r_state == ST_GAP) || (w_release && !r_gap);
        w_grant     = w_arb && w_pick_any;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_GAP: w_state_nxt = w_grant ? ST_OWN : ST_IDLE;
            ST_OWN: begin
                if (!w_release)  w_state_nxt = ST_OWN;
                else if (r_gap)  w_state_nxt = ST_GAP;
                else             w_state_nxt = w_grant ? ST_OWN : ST_IDLE;
            end
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath next values; burst and gap config are captured only on a grant.
    always_comb begin
        w_gnt_nxt   = '0;
        w_id_nxt    = '0;
        w_vld_nxt   = 1'b0;
        w_burst_nxt = '0;
        w_gap_nxt   = r_gap;
        w_cnt_nxt   = r_grant_cnt;
        w_ptr_nxt   = w_release ? w_ptr_adv : r_rr_ptr;
        if (w_grant) begin
            w_gnt_nxt   = w_pick_onehot;
            w_id_nxt    = w_pick_idx;
            w_vld_nxt   = 1'b1;
            w_burst_nxt = (cfg_burst == '0) ? BURST_MAX : {1'b0, cfg_burst};
            w_gap_nxt   = cfg_gap;
            w_cnt_nxt   = r_grant_cnt + 1'b1;
        end else if (r_state == ST_OWN && !w_release) begin
            w_gnt_nxt   = r_gnt;
            w_id_nxt    = r_gnt_id;
            w_vld_nxt   = 1'b1;
            w_burst_nxt = r_burst_cnt - 1'b1;
        end
    end

    assign gnt        = r_gnt;
    assign gnt_id     = r_gnt_id;
    assign gnt_vld    = r_gnt_vld;
    assign slot_phase = r_slot_phase;
    assign grant_cnt  = r_grant_cnt;

endmodule

// File: tb/tb_dubl_slot_arb.sv
// tb/tb_dubl_slot_arb.sv - scoreboard bench for the slot arbiter against a slot-level model
module tb_dubl_slot_arb;

    localparam int N  = 4;
    localparam int BW = 3;

    logic        dubl_clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [2:0]  cfg_burst;
    logic        cfg_gap;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_vld;
    logic        slot_phase;
    logic [15:0] grant_cnt;

    dubl_slot_arb #(.N(N), .BW(BW)) dut (
        .dubl_clk   (dubl_clk),
        .rst_n      (rst_n),
        .req        (req),
        .cfg_burst  (cfg_burst),
        .cfg_gap    (cfg_gap),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_vld    (gnt_vld),
        .slot_phase (slot_phase),
        .grant_cnt  (grant_cnt)
    );

    initial dubl_clk = 1'b0;
    always #5 dubl_clk = ~dubl_clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic        vld;
        logic [15:0] cnt;
        logic        phase;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: owner index (-1 = none), slots already owned, burst length, gap flag.
    int          owner_m = -1;
    int          used_m  = 0;
    int          len_m   = 0;
    bit          gap_m   = 0;
    int          ptr_m   = 0;
    logic [15:0] cnt_m   = 0;
    bit          phase_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner_m = -1; used_m = 0; len_m = 0; gap_m = 0;
        ptr_m = 0; cnt_m = 0; phase_m = 0;
    endtask

    // Drive inputs for the next edge, advance the model by one slot, queue its view.
    task automatic step(input logic [3:0] r, input logic [2:0] b, input logic g);
        bit   dead;
        exp_t e;
        req = r; cfg_burst = b; cfg_gap = g;
        dead = 0;
        phase_m = ~phase_m;
        if (owner_m >= 0) begin
            if (used_m == len_m || !r[owner_m]) begin
                ptr_m   = (owner_m + 1) % N;
                dead    = gap_m;
                owner_m = -1;
            end else begin
                used_m++;
            end
        end
        if (owner_m < 0 && !dead) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (ptr_m + j) % N;
                if (r[c]) begin
                    owner_m = c;
                    used_m  = 1;
                    len_m   = (b == 0) ? 8 : int'(b);
                    gap_m   = g;
                    cnt_m   = cnt_m + 16'd1;
                    break;
                end
            end
        end
        e.gnt   = (owner_m >= 0) ? 4'(1 << owner_m) : 4'b0;
        e.id    = (owner_m >= 0) ? 2'(owner_m) : 2'd0;
        e.vld   = (owner_m >= 0);
        e.cnt   = cnt_m;
        e.phase = phase_m;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt),        32'h0);
        chk({tag, "_id"},    32'(gnt_id),     32'h0);
        chk({tag, "_vld"},   32'(gnt_vld),    32'h0);
        chk({tag, "_cnt"},   32'(grant_cnt),  32'h0);
        chk({tag, "_phase"}, 32'(slot_phase), 32'h0);
    endtask

    // Monitor: every edge the DUT presents a slot; compare against the queued model view.
    initial begin
        exp_t e;
        forever begin
            @(posedge dubl_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",        32'(gnt),        32'(e.gnt));
                chk("gnt_id",     32'(gnt_id),     32'(e.id));
                chk("gnt_vld",    32'(gnt_vld),    32'(e.vld));
                chk("grant_cnt",  32'(grant_cnt),  32'(e.cnt));
                chk("slot_phase", 32'(slot_phase), 32'(e.phase));
                chk("onehot",     32'($countones(gnt) <= 1), 32'h1);
                if (gnt_vld) chk("id_match", 32'(gnt[gnt_id]), 32'h1);
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; cfg_burst = '0; cfg_gap = 1'b0;
        model_reset();
        @(negedge dubl_clk);
        @(negedge dubl_clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Sole requester, burst 3, no gap: three slots then immediate regrant.
        for (int i = 0; i < 6; i++) begin step(4'b0001, 3'd3, 1'b0); @(negedge dubl_clk); end
        for (int i = 0; i < 3; i++) begin step(4'b0000, 3'd3, 1'b0); @(negedge dubl_clk); end
        // All requesting, single-slot bursts: rotate through every requester.
        for (int i = 0; i < 6; i++) begin step(4'b1111, 3'd1, 1'b0); @(negedge dubl_clk); end
        // Two requesters with a dead slot between owners.
        for (int i = 0; i < 8; i++) begin step(4'b0101, 3'd2, 1'b1); @(negedge dubl_clk); end

        // Owner 2 with an 8-slot burst drops its request after three slots.
        for (int i = 0; i < 20 && !(owner_m == 2 && used_m == 1); i++) begin
            step(4'b0100, 3'd0, 1'b0); @(negedge dubl_clk);
        end
        chk("owner2_reached", 32'(owner_m), 32'd2);
        for (int i = 0; i < 2; i++) begin step(4'b0100, 3'd1, 1'b1); @(negedge dubl_clk); end
        step(4'b0000, 3'd0, 1'b0); @(negedge dubl_clk);
        for (int i = 0; i < 3; i++) begin step(4'b1001, 3'd2, 1'b0); @(negedge dubl_clk); end

        // Reset in the middle of owner 3's burst, then first edge regrants 3.
        for (int i = 0; i < 12; i++) begin step(4'b1000, 3'd0, 1'b0); @(negedge dubl_clk); end
        chk("owner3_mid_burst", 32'(gnt_vld && gnt_id == 2'd3), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge dubl_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin step(4'b1000, 3'd2, 1'b0); @(negedge dubl_clk); end

        // Random traffic with config changing freely mid-burst.
        begin
            logic [3:0] r;
            r = 4'(1 + $urandom_range(0, 14));
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                step(r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                @(negedge dubl_clk);
            end
        end

        // Enough single-slot grants to wrap the grant counter.
        for (int i = 0; i < 65540; i++) begin step(4'b0001, 3'd1, 1'b0); @(negedge dubl_clk); end

        @(negedge dubl_clk);
        @(negedge dubl_clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
